data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Arbitrates one data-memory port between the pipeline MEM stage and a debug/loader port.
// The pipeline normally owns the port. A debug request waits at most MAX_WAIT busy cycles before it is granted.
module data_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline MEM stage
  input  logic              p_rden,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  // debug / loader requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  // shared memory port
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_rden,
  output logic              m_wren,
  input  logic [DATA_W-1:0] m_q,
  // observation of internal state
  output logic [1:0]        o_dbg_state,
  output logic [2:0]        o_dbg_wait_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  localparam logic [2:0] LP_MAX_WAIT = 3'(MAX_WAIT);

  // Debug handshake: d_req is a level held with d_we/d_addr/d_wdata stable
  // until the single-cycle d_ack pulse; ACK ignores d_req, so the requester
  // may drop it during or after the ack cycle.

  logic [1:0]        r_state;
  logic [2:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_p_acc;
  logic w_grant;
  logic w_timeout;

  assign w_p_acc   = p_rden | p_wren;
  assign w_grant   = (r_state == GRANT);
  assign w_timeout = (r_wait_cnt == LP_MAX_WAIT);

  // The port belongs to the pipeline except during GRANT. Reset forces IDLE
  // asynchronously, so an aborted debug drive drops immediately.
  always_comb begin
    m_addr  = p_addr;
    m_data  = p_wdata;
    m_rden  = p_rden;
    m_wren  = p_wren;
    p_stall = 1'b0;
    if (w_grant) begin
      m_addr  = d_addr;
      m_data  = d_wdata;
      m_rden  = ~d_we;
      m_wren  = d_we;
      p_stall = w_p_acc;
    end
  end

  assign p_rdata        = m_q;
  assign d_ack          = (r_state == ACK);
  assign d_rdata        = r_d_rdata;
  assign o_dbg_state    = r_state;
  assign o_dbg_wait_cnt = r_wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= 3'd0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (d_req) begin
            if (!w_p_acc || w_timeout) begin
              r_state    <= GRANT;
              r_wait_cnt <= 3'd0;
            end else begin
              r_wait_cnt <= r_wait_cnt + 3'd1;
            end
          end else begin
            r_wait_cnt <= 3'd0;
          end
        end
        GRANT: begin
          r_state <= d_we ? ACK : CAPTURE;
        end
        CAPTURE: begin
          // Memory returns the debug read data the cycle after GRANT.
          r_d_rdata <= m_q;
          r_state   <= ACK;
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
